// File: rtl/seq_mac_multiplier.sv
// Iterative shift-add multiply-accumulate: one WIDTH x WIDTH signed/unsigned product
// over WIDTH+1 cycles, optionally added to or subtracted from an internal accumulator.
module seq_mac_multiplier #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 a_signed,
  input  logic                 b_signed,
  input  logic [1:0]           op,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH:0]     product,
  output logic [ACC_W-1:0]     result,
  output logic                 ovf
);

  localparam int PW    = 2*WIDTH+1;
  localparam int PS_W  = 2*WIDTH+2;
  localparam int CNT_W = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          count;
  logic signed [WIDTH:0]     a_ext, b_ext;
  logic                      b_sgn;
  logic [1:0]                op_q;
  logic signed [PS_W-1:0]    psum, psum_nxt, term;
  logic signed [PW-1:0]      prod_nxt;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W:0]     sum_nxt;
  logic                      last_iter, accept, acc_op;

  function automatic logic signed [WIDTH:0] ext_operand(input logic [WIDTH-1:0] v,
                                                        input logic sgn);
    return {sgn & v[WIDTH-1], v};
  endfunction

  // One guard bit above the accumulator so the true sum is always representable.
  function automatic logic signed [ACC_W:0] acc_sum(input logic signed [ACC_W-1:0] acc_in,
                                                    input logic signed [PW-1:0]    p,
                                                    input logic [1:0]              op_in);
    logic signed [ACC_W:0] acc_w, p_w;
    acc_w = (ACC_W+1)'(acc_in);
    p_w   = (ACC_W+1)'(p);
    case (op_in)
      2'b01:   return acc_w + p_w;
      2'b10:   return acc_w - p_w;
      default: return p_w;
    endcase
  endfunction

  function automatic logic signed_ovf(input logic signed [ACC_W:0] s, input logic is_acc);
    return is_acc & (s[ACC_W] ^ s[ACC_W-1]);
  endfunction

  assign in_ready  = (state == IDLE) & rst_n;
  assign accept    = in_valid & in_ready;
  assign last_iter = (count == CNT_W'(WIDTH));
  assign acc_op    = (op_q == 2'b01) | (op_q == 2'b10);

  // The top bit of b_ext carries negative weight, so the last partial product is subtracted.
  always_comb begin
    term     = b_ext[count] ? ((PS_W)'(a_ext) <<< count) : '0;
    psum_nxt = (last_iter && b_sgn) ? (psum - term) : (psum + term);
    prod_nxt = psum_nxt[PW-1:0];
    sum_nxt  = acc_sum(acc, prod_nxt, op_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = BUSY;
      BUSY:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      a_ext     <= '0;
      b_ext     <= '0;
      b_sgn     <= 1'b0;
      op_q      <= 2'b00;
      psum      <= '0;
      acc       <= '0;
      product   <= '0;
      result    <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_clr) acc <= '0;
          if (accept) begin
            a_ext <= ext_operand(a, a_signed);
            b_ext <= ext_operand(b, b_signed);
            b_sgn <= b_signed;
            op_q  <= op;
            psum  <= '0;
            count <= '0;
          end
        end
        BUSY: begin
          psum  <= psum_nxt;
          count <= count + 1'b1;
          if (last_iter) begin
            product   <= prod_nxt;
            acc       <= sum_nxt[ACC_W-1:0];
            result    <= sum_nxt[ACC_W-1:0];
            ovf       <= signed_ovf(sum_nxt, acc_op);
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mac_multiplier.sv
// Directed bench for seq_mac_multiplier: a 24-bit-accumulator instance for the main
// features and a 17-bit-accumulator instance for the overflow boundary.
module tb_seq_mac_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_a = 1'b0, in_valid_b = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        a_signed = 1'b0, b_signed = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        acc_clr = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_a, out_valid_a, ovf_a;
  logic [16:0] product_a;
  logic [23:0] result_a;
  logic        in_ready_b, out_valid_b, ovf_b;
  logic [16:0] product_b;
  logic [16:0] result_b;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  seq_mac_multiplier #(.WIDTH(8), .ACC_W(24)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .op(op), .acc_clr(acc_clr),
    .out_valid(out_valid_a), .out_ready(out_ready), .product(product_a),
    .result(result_a), .ovf(ovf_a)
  );

  seq_mac_multiplier #(.WIDTH(8), .ACC_W(17)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .a(a), .b(b), .a_signed(a_signed), .b_signed(b_signed), .op(op), .acc_clr(acc_clr),
    .out_valid(out_valid_b), .out_ready(out_ready), .product(product_b),
    .result(result_b), .ovf(ovf_b)
  );

  // Present one beat, let it be accepted, then count edges until out_valid (bounded).
  task automatic issue(input logic sel, input logic [7:0] ia, input logic [7:0] ib,
                       input logic sa, input logic sb, input logic [1:0] iop,
                       input logic clr, output int lat);
    @(negedge clk);
    a = ia; b = ib; a_signed = sa; b_signed = sb; op = iop; acc_clr = clr;
    if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0; in_valid_b = 1'b0; acc_clr = 1'b0;
    lat = 0;
    while (!(sel ? out_valid_b : out_valid_a) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nchk++; if (in_ready_a !== 1'b0) begin nfail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready_a); end
    nchk++; if (out_valid_a !== 1'b0) begin nfail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_a); end
    nchk++; if (result_a !== 24'h0 || product_a !== 17'h0 || ovf_a !== 1'b0) begin
      nfail++; $display("FAIL reset_outputs got=%h/%h/%b exp=0/0/0", result_a, product_a, ovf_a); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    nchk++; if (in_ready_a !== 1'b1) begin nfail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready_a); end
  endtask

  task automatic test_mul_signed();
    int lat;
    issue(1'b0, 8'h80, 8'h80, 1'b1, 1'b1, 2'b00, 1'b0, lat);
    nchk++; if (lat !== 9) begin nfail++; $display("FAIL mul_latency got=%0d exp=9", lat); end
    nchk++; if (product_a !== 17'h04000) begin nfail++; $display("FAIL mul_product got=%h exp=04000", product_a); end
    nchk++; if (result_a !== 24'h004000) begin nfail++; $display("FAIL mul_result got=%h exp=004000", result_a); end
    nchk++; if (ovf_a !== 1'b0) begin nfail++; $display("FAIL mul_ovf got=%b exp=0", ovf_a); end
    release_result();
    nchk++; if (out_valid_a !== 1'b0) begin nfail++; $display("FAIL mul_release got=%b exp=0", out_valid_a); end
  endtask

  task automatic test_signedness();
    int lat;
    issue(1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0, 2'b00, 1'b0, lat);
    nchk++; if (product_a !== 17'h0FE01) begin nfail++; $display("FAIL uu_product got=%h exp=0fe01", product_a); end
    nchk++; if (result_a !== 24'h00FE01) begin nfail++; $display("FAIL uu_result got=%h exp=00fe01", result_a); end
    release_result();
    issue(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 2'b00, 1'b0, lat);
    nchk++; if (product_a !== 17'h1FF01) begin nfail++; $display("FAIL su_product got=%h exp=1ff01", product_a); end
    nchk++; if (result_a !== 24'hFFFF01) begin nfail++; $display("FAIL su_result got=%h exp=ffff01", result_a); end
    release_result();
  endtask

  task automatic test_accumulate();
    int lat;
    issue(1'b0, 8'd3, 8'd4, 1'b1, 1'b1, 2'b00, 1'b0, lat);
    nchk++; if (result_a !== 24'd12) begin nfail++; $display("FAIL acc_mul got=%h exp=00000c", result_a); end
    release_result();
    issue(1'b0, 8'hFB, 8'd6, 1'b1, 1'b1, 2'b01, 1'b0, lat);
    nchk++; if (product_a !== 17'h1FFE2) begin nfail++; $display("FAIL acc_mac_product got=%h exp=1ffe2", product_a); end
    nchk++; if (result_a !== 24'hFFFFEE) begin nfail++; $display("FAIL acc_mac got=%h exp=ffffee", result_a); end
    release_result();
    issue(1'b0, 8'd2, 8'd2, 1'b1, 1'b1, 2'b10, 1'b0, lat);
    nchk++; if (result_a !== 24'hFFFFEA) begin nfail++; $display("FAIL acc_msub got=%h exp=ffffea", result_a); end
    nchk++; if (ovf_a !== 1'b0) begin nfail++; $display("FAIL acc_msub_ovf got=%b exp=0", ovf_a); end
    release_result();
    issue(1'b0, 8'd1, 8'd1, 1'b1, 1'b1, 2'b01, 1'b1, lat);
    nchk++; if (result_a !== 24'd1) begin nfail++; $display("FAIL acc_clr_mac got=%h exp=000001", result_a); end
    release_result();
    issue(1'b0, 8'd3, 8'd3, 1'b1, 1'b1, 2'b11, 1'b0, lat);
    nchk++; if (result_a !== 24'd9) begin nfail++; $display("FAIL op11_as_mul got=%h exp=000009", result_a); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [23:0] held;
    issue(1'b0, 8'd5, 8'd5, 1'b0, 1'b0, 2'b00, 1'b0, lat);
    held = result_a;
    nchk++; if (held !== 24'd25) begin nfail++; $display("FAIL bp_first got=%h exp=000019", held); end
    @(negedge clk);
    a = 8'd2; b = 8'd3; a_signed = 1'b0; b_signed = 1'b0; op = 2'b01; in_valid_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nchk++; if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0 || result_a !== 24'd25) begin
        nfail++; $display("FAIL bp_hold cyc=%0d got=%b/%b/%h exp=1/0/000019", i, out_valid_a, in_ready_a, result_a); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    nchk++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      nfail++; $display("FAIL bp_idle got=%b/%b exp=0/1", out_valid_a, in_ready_a); end
    @(posedge clk); #1; in_valid_a = 1'b0;
    lat = 0;
    while (!out_valid_a && lat < 40) begin @(posedge clk); #1; lat++; end
    nchk++; if (lat !== 9) begin nfail++; $display("FAIL bp_pending_latency got=%0d exp=9", lat); end
    nchk++; if (result_a !== 24'd31) begin nfail++; $display("FAIL bp_pending_result got=%h exp=00001f", result_a); end
    release_result();
  endtask

  task automatic test_reset_busy();
    int lat;
    @(negedge clk);
    a = 8'd7; b = 8'd7; a_signed = 1'b1; b_signed = 1'b1; op = 2'b01; in_valid_a = 1'b1;
    @(posedge clk); #1; in_valid_a = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    nchk++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b0) begin
      nfail++; $display("FAIL rst_busy_ctrl got=%b/%b exp=0/0", out_valid_a, in_ready_a); end
    nchk++; if (result_a !== 24'h0 || product_a !== 17'h0 || ovf_a !== 1'b0) begin
      nfail++; $display("FAIL rst_busy_outputs got=%h/%h/%b exp=0/0/0", result_a, product_a, ovf_a); end
    repeat (12) @(posedge clk);
    #1;
    nchk++; if (out_valid_a !== 1'b0) begin nfail++; $display("FAIL rst_busy_no_valid got=%b exp=0", out_valid_a); end
    @(negedge clk); rst_n = 1'b1;
    issue(1'b0, 8'd2, 8'd3, 1'b1, 1'b1, 2'b01, 1'b0, lat);
    nchk++; if (result_a !== 24'd6) begin nfail++; $display("FAIL rst_busy_after got=%h exp=000006", result_a); end
    release_result();
  endtask

  task automatic test_overflow();
    int lat;
    logic [16:0] exp_r [4] = '{17'h04000, 17'h08000, 17'h0C000, 17'h10000};
    logic        exp_o [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 8'h80, 8'h80, 1'b1, 1'b1, (i == 0) ? 2'b00 : 2'b01, 1'b0, lat);
      nchk++; if (result_b !== exp_r[i]) begin nfail++; $display("FAIL ovf_result step=%0d got=%h exp=%h", i, result_b, exp_r[i]); end
      nchk++; if (ovf_b !== exp_o[i]) begin nfail++; $display("FAIL ovf_flag step=%0d got=%b exp=%b", i, ovf_b, exp_o[i]); end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_mul_signed();
    test_signedness();
    test_accumulate();
    test_back_to_back();
    test_reset_busy();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
